edge_detect_multi: RTL and testbench

//  Parametrised multi-channel level-to-pulse edge detector. Per channel: N-flop

---
 rtl/edge_detect_multi.sv | 103 ++++++++++
 tb/tb_edge_detect_multi.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: multi-channel level-to-pulse edge detector.
// Each channel has its own synchroniser, debounce counter, Moore FSM and
// sticky flag. The tick, sticky and any_event outputs are gated by mode.
module edge_detect_multi #(
  parameter int unsigned CH          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [CH-1:0]   level,
  input  logic [1:0]      mode,
  input  logic [DB_W-1:0] db_limit,
  input  logic [CH-1:0]   sticky_clr,
  output logic [CH-1:0]   rise,
  output logic [CH-1:0]   fall,
  output logic [CH-1:0]   tick,
  output logic [CH-1:0]   stable,
  output logic [CH-1:0]   sticky,
  output logic            any_event
);

  typedef enum logic [1:0] {
    S_ZERO = 2'd0,
    S_RISE = 2'd1,
    S_ONE  = 2'd2,
    S_FALL = 2'd3
  } state_t;

  logic [CH-1:0] w_tick;
  logic [CH-1:0] r_sticky;

  for (genvar g = 0; g < CH; g++) begin : gen_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_lvl;
    logic [DB_W-1:0]        r_cnt;
    logic [DB_W-1:0]        w_cnt_nxt;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_stable;

    // Synchroniser shift chain; runs even while detection is disabled
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sync <= '0;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], level[g]};
    end

    assign w_sync_lvl = r_sync[SYNC_STAGES-1];
    assign w_stable   = (r_state == S_RISE) || (r_state == S_ONE);

    // Debounce counting and FSM next-state; RISE/FALL hold the counter at zero
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      if (!en) begin
        // Disabled: track the synced level directly so re-enabling cannot pulse
        w_state_nxt = w_sync_lvl ? S_ONE : S_ZERO;
      end else begin
        case (r_state)
          S_RISE: w_state_nxt = S_ONE;
          S_FALL: w_state_nxt = S_ZERO;
          default: begin
            if (w_sync_lvl != w_stable) begin
              if (r_cnt < db_limit) begin
                w_cnt_nxt = r_cnt + 1'b1;
              end else begin
                w_state_nxt = w_stable ? S_FALL : S_RISE;
              end
            end
          end
        endcase
      end
    end

    // State and debounce counter registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= S_ZERO;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    assign rise[g]   = (r_state == S_RISE);
    assign fall[g]   = (r_state == S_FALL);
    assign stable[g] = w_stable;
  end

  assign w_tick    = (rise & {CH{mode[0]}}) | (fall & {CH{mode[1]}});
  assign tick      = w_tick;
  assign any_event = |w_tick;
  assign sticky    = r_sticky;

  // Sticky flags: a tick wins over a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sticky <= '0;
    else       r_sticky <= w_tick | (r_sticky & ~sticky_clr);
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Testbench for edge_detect_multi: directed scenario tasks plus a randomized
// run checked against a behavioural model (delay line + run-length debounce).
module tb_edge_detect_multi;
  localparam int unsigned CH   = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DB_W = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b1;
  logic [CH-1:0]   level = '0;
  logic [1:0]      mode = 2'b11;
  logic [DB_W-1:0] db_limit = '0;
  logic [CH-1:0]   sticky_clr = '0;
  logic [CH-1:0]   rise, fall, tick, stable, sticky;
  logic            any_event;

  int checks = 0;
  int failures = 0;

  edge_detect_multi #(.CH(CH), .SYNC_STAGES(SYNC), .DB_W(DB_W)) dut (
    .clk(clk), .reset(reset), .en(en), .level(level), .mode(mode),
    .db_limit(db_limit), .sticky_clr(sticky_clr), .rise(rise), .fall(fall),
    .tick(tick), .stable(stable), .sticky(sticky), .any_event(any_event)
  );

  always #5 clk = ~clk;

  // Behavioural model: synced level is the input delayed by SYNC samples;
  // a change is accepted once it has disagreed for db_limit+1 counted cycles,
  // and the cycle right after a pulse is never counted.
  logic [SYNC-1:0] m_hist [CH];
  logic [CH-1:0]   m_stable, m_rise, m_fall, m_sticky;
  int              m_run [CH];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin m_hist[c] = '0; m_run[c] = 0; end
      m_stable = '0; m_rise = '0; m_fall = '0; m_sticky = '0;
    end else begin
      logic [CH-1:0] tk, nr, nf;
      logic s;
      tk = (m_rise & {CH{mode[0]}}) | (m_fall & {CH{mode[1]}});
      m_sticky = tk | (m_sticky & ~sticky_clr);
      nr = '0; nf = '0;
      for (int c = 0; c < CH; c++) begin
        s = m_hist[c][SYNC-1];
        if (!en) begin
          m_stable[c] = s; m_run[c] = 0;
        end else if (m_rise[c] || m_fall[c]) begin
          m_run[c] = 0;
        end else if (s != m_stable[c]) begin
          if (m_run[c] >= int'(db_limit)) begin
            m_stable[c] = s; nr[c] = s; nf[c] = ~s; m_run[c] = 0;
          end else begin
            m_run[c] = m_run[c] + 1;
          end
        end else begin
          m_run[c] = 0;
        end
        m_hist[c] = {m_hist[c][SYNC-2:0], level[c]};
      end
      m_rise = nr; m_fall = nf;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; level = '0; sticky_clr = '0; en = 1'b1; mode = 2'b11; db_limit = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1; level = '1; mode = 2'b11;
    #1;
    checks++;
    if ({rise, fall, tick, stable, sticky, any_event} !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", {rise, fall, tick, stable, sticky, any_event});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({rise, fall, tick, stable, sticky, any_event} !== '0) begin
      failures++;
      $display("FAIL reset_held got=%h exp=0", {rise, fall, tick, stable, sticky, any_event});
    end
  endtask

  task automatic test_latency();
    do_reset();
    step(); level[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({rise[0], tick[0], stable[0], sticky[0]} !== {i == 2, i == 2, i >= 2, i >= 3}) begin
        failures++;
        $display("FAIL latency edge=k+%0d got(r,t,s,st)=%b exp=%b", i,
                 {rise[0], tick[0], stable[0], sticky[0]}, {i == 2, i == 2, i >= 2, i >= 3});
      end
    end
  endtask

  task automatic test_debounce();
    do_reset();
    db_limit = 4'd3;
    step(); level[1] = 1'b1;
    repeat (3) step();
    level[1] = 1'b0;
    repeat (12) begin
      @(negedge clk);
      checks++;
      if ({rise[1], stable[1]} !== 2'b00) begin
        failures++;
        $display("FAIL glitch got(r,s)=%b exp=00", {rise[1], stable[1]});
      end
      @(posedge clk);
    end
    #1 level[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      if (i == 3) #1 level[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (rise[1] !== (i == 5)) begin
        failures++;
        $display("FAIL db_rise edge=k+%0d got=%b exp=%b", i, rise[1], i == 5);
      end
    end
    repeat (12) step();
    level[1] = 1'b1;
    repeat (14) step();
    level[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({fall[1], stable[1]} !== {i == 5, i < 5}) begin
        failures++;
        $display("FAIL db_fall edge=d+%0d got(f,s)=%b exp=%b", i, {fall[1], stable[1]}, {i == 5, i < 5});
      end
    end
  endtask

  task automatic test_mode();
    int nr, nf, nt, na;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      mode = (pass == 0) ? 2'b01 : 2'b00;
      nr = 0; nf = 0; nt = 0; na = 0;
      for (int j = 0; j < 16; j++) begin
        @(posedge clk); #1;
        if (j == 0) level[4] = 1'b1;
        if (j == 8) level[4] = 1'b0;
        @(negedge clk);
        nr += int'(rise[4]); nf += int'(fall[4]); nt += int'(tick[4]); na += int'(any_event);
      end
      checks++;
      if ({nr, nf, nt, na} !== {32'd1, 32'd1, 32'(1 - pass), 32'(1 - pass)}) begin
        failures++;
        $display("FAIL mode%0d counts rise=%0d fall=%0d tick=%0d any=%0d exp 1 1 %0d %0d",
                 pass, nr, nf, nt, na, 1 - pass, 1 - pass);
      end
      checks++;
      if (sticky[4] !== (pass == 0)) begin
        failures++;
        $display("FAIL mode%0d sticky got=%b exp=%b", pass, sticky[4], pass == 0);
      end
    end
  endtask

  task automatic test_sticky_clr();
    do_reset();
    step(); level[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) sticky_clr[2] = 1'b1;
      if (i == 4) sticky_clr[2] = 1'b0;
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if ({tick[2], sticky[2]} !== {i == 2, i == 3}) begin
          failures++;
          $display("FAIL sticky_clr edge=k+%0d got(t,st)=%b exp=%b", i, {tick[2], sticky[2]}, {i == 2, i == 3});
        end
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0;
    level[3] = 1'b1; repeat (2) step();
    level[3] = 1'b0; repeat (3) step();
    level[3] = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 8) begin @(posedge clk); #1 en = 1'b1; end
      @(negedge clk);
      checks++;
      if ({rise, fall} !== '0 || (i >= 4 && stable[3] !== 1'b1)) begin
        failures++;
        $display("FAIL enable cyc=%0d rise=%b fall=%b stable3=%b exp rise=0 fall=0 stable3=1",
                 i, rise, fall, stable[3]);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int nr;
    reset = 1'b1; level = '1; sticky_clr = '0; en = 1'b1; mode = 2'b11; db_limit = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (rise !== ((i == 2) ? {CH{1'b1}} : {CH{1'b0}})) begin
        failures++;
        $display("FAIL release_rise edge=k+%0d got=%b exp=%b", i, rise, (i == 2) ? {CH{1'b1}} : {CH{1'b0}});
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({rise, fall, tick, stable, sticky, any_event} !== '0) begin
      failures++;
      $display("FAIL reset_mid_rise got=%h exp=0", {rise, fall, tick, stable, sticky, any_event});
    end
    #2 reset = 1'b0;
    nr = 0;
    repeat (10) begin
      @(negedge clk);
      nr += $countones(rise);
    end
    checks++;
    if (nr !== CH) begin
      failures++;
      $display("FAIL reset_mid_rerise got=%0d exp=%0d", nr, CH);
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] et;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) level[c] = ~level[c];
      if ($urandom_range(0, 49) == 0) db_limit = DB_W'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 79) == 0) en = ~en;
      sticky_clr = CH'($urandom & $urandom & $urandom);
      @(negedge clk);
      et = (m_rise & {CH{mode[0]}}) | (m_fall & {CH{mode[1]}});
      checks++;
      if ({rise, fall, tick, stable, sticky, any_event} !== {m_rise, m_fall, et, m_stable, m_sticky, |et}) begin
        failures++;
        $display("FAIL random cyc=%0d got r=%b f=%b t=%b s=%b st=%b a=%b exp r=%b f=%b t=%b s=%b st=%b a=%b",
                 n, rise, fall, tick, stable, sticky, any_event,
                 m_rise, m_fall, et, m_stable, m_sticky, |et);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_debounce();
    test_mode();
    test_sticky_clr();
    test_enable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
